// File: rtl/spi_reg_writer.sv
// Parses framed SPI write commands (opcode, address, data...) into an NREGS x 8-bit register bank.
// Optional saturating error counter is built only when SPI_REG_WRITER_ERRCNT_EN is defined.
module spi_reg_writer #(
    parameter int NREGS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    input  logic               frame_active,
    output logic [NREGS*8-1:0] regs,
    output logic               wr_strobe,
    output logic [7:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               frame_err,
    output logic [7:0]         err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [8:0] NREGS_W   = 9'(NREGS);
    localparam logic [7:0] LAST_ADDR = 8'(NREGS - 1);

    state_t     state;
    logic       burst;
    logic [7:0] addr;
    logic       frame_q;
    logic       take;
    logic       enter_err;

    assign take = rx_valid & frame_active;

    always_comb begin
        enter_err = 1'b0;
        if (take) begin
            case (state)
                S_IDLE:  enter_err = (rx_byte != 8'h01) && (rx_byte != 8'h02);
                S_ADDR:  enter_err = ({1'b0, rx_byte} >= NREGS_W);
                S_DONE:  enter_err = 1'b1;
                default: enter_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            burst     <= 1'b0;
            addr      <= 8'h00;
            frame_q   <= 1'b0;
            regs      <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_q   <= frame_active;
            // A new frame clears the flag, but an error on its first byte must win.
            if (frame_active && !frame_q)
                frame_err <= 1'b0;
            if (enter_err)
                frame_err <= 1'b1;

            if (!frame_active) begin
                state <= S_IDLE;
            end else if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                            burst <= (rx_byte == 8'h02);
                            state <= S_ADDR;
                        end else begin
                            state <= S_ERROR;
                        end
                    end
                    S_ADDR: begin
                        if ({1'b0, rx_byte} < NREGS_W) begin
                            addr  <= rx_byte;
                            state <= S_DATA;
                        end else begin
                            state <= S_ERROR;
                        end
                    end
                    S_DATA: begin
                        for (int i = 0; i < NREGS; i++) begin
                            if (addr == 8'(i))
                                regs[8*i +: 8] <= rx_byte;
                        end
                        wr_strobe <= 1'b1;
                        wr_addr   <= addr;
                        wr_data   <= rx_byte;
                        if (burst)
                            addr <= (addr == LAST_ADDR) ? 8'h00 : addr + 8'h01;
                        else
                            state <= S_DONE;
                    end
                    S_DONE:  state <= S_ERROR;
                    default: state <= S_ERROR;
                endcase
            end
        end
    end

`ifdef SPI_REG_WRITER_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= 8'h00;
        else if (enter_err && err_count != 8'hFF)
            err_count <= err_count + 8'h01;
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: expected writes are queued as frames are driven
// and popped by a strobe monitor; each scenario task also checks registers and flags.
module tb_spi_reg_writer;

    localparam int NREGS = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_byte = 8'h00;
    logic               rx_valid = 1'b0;
    logic               frame_active = 1'b0;
    logic [NREGS*8-1:0] regs;
    logic               wr_strobe;
    logic [7:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               frame_err;
    logic [7:0]         err_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    int strobe_cnt = 0;
    logic [15:0]        exp_q[$];
    logic [NREGS*8-1:0] exp_regs = '0;
    logic [7:0]         exp_err = 8'h00;
    logic [7:0]         exp_addr = 8'h00;
    logic [7:0]         exp_data = 8'h00;

    spi_reg_writer #(.NREGS(NREGS)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_active (frame_active),
        .regs         (regs),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            logic [15:0] e;
            strobe_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: got addr=%02h data=%02h, required no strobe", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e)
                    $display("FAIL strobe_payload: got %02h/%02h, required %02h/%02h",
                             wr_addr, wr_data, e[15:8], e[7:0]);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        exp_regs[8*a +: 8] = d;
        exp_addr = a;
        exp_data = d;
    endtask

    task automatic bump_err();
`ifdef SPI_REG_WRITER_ERRCNT_EN
        if (exp_err != 8'hFF) exp_err = exp_err + 8'h01;
`endif
    endtask

    // Bytes on consecutive cycles with frame_active high; ends on the negedge after the last byte.
    task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] b [5];
        b = '{b0, b1, b2, b3, b4};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_active = 1'b1;
            rx_byte      = b[i];
            rx_valid     = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (regs !== '0) $display("FAIL reset_regs: got %h, required 0", regs); else pass_cnt++;
        total_cnt++;
        if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b, required 0", wr_strobe); else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, required 0", frame_err); else pass_cnt++;
        total_cnt++;
        if (err_count !== 8'h00) $display("FAIL reset_err_count: got %02h, required 00", err_count); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int s0 = strobe_cnt;
        push_wr(8'h03, 8'hA5);
        send_bytes(3, 8'h01, 8'h03, 8'hA5, 8'h00, 8'h00);
        total_cnt++;
        if (wr_strobe !== 1'b1) $display("FAIL single_strobe_hi: got %b, required 1", wr_strobe); else pass_cnt++;
        total_cnt++;
        if (regs !== exp_regs) $display("FAIL single_regs: got %h, required %h", regs, exp_regs); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wr_strobe !== 1'b0) $display("FAIL single_strobe_lo: got %b, required 0", wr_strobe); else pass_cnt++;
        end_frame();
        total_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL single_count: got %0d, required 1", strobe_cnt - s0); else pass_cnt++;
        total_cnt++;
        if ({wr_addr, wr_data} !== {exp_addr, exp_data})
            $display("FAIL single_last_wr: got %02h/%02h, required %02h/%02h", wr_addr, wr_data, exp_addr, exp_data);
        else pass_cnt++;
    endtask

    task automatic test_burst();
        int s0 = strobe_cnt;
        push_wr(8'h06, 8'h11);
        push_wr(8'h07, 8'h22);
        push_wr(8'h00, 8'h33);
        send_bytes(5, 8'h02, 8'h06, 8'h11, 8'h22, 8'h33);
        end_frame();
        total_cnt++;
        if (regs !== exp_regs) $display("FAIL burst_regs: got %h, required %h", regs, exp_regs); else pass_cnt++;
        total_cnt++;
        if (strobe_cnt - s0 !== 3) $display("FAIL burst_count: got %0d, required 3", strobe_cnt - s0); else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL burst_frame_err: got %b, required 0", frame_err); else pass_cnt++;
    endtask

    task automatic test_bad_frames();
        int s0 = strobe_cnt;
        send_bytes(2, 8'h7F, 8'h12, 8'h00, 8'h00, 8'h00);
        bump_err();
        end_frame();
        total_cnt++;
        if (frame_err !== 1'b1) $display("FAIL bad_opcode_err: got %b, required 1", frame_err); else pass_cnt++;
        total_cnt++;
        if (err_count !== exp_err) $display("FAIL bad_opcode_cnt: got %02h, required %02h", err_count, exp_err); else pass_cnt++;
        send_bytes(3, 8'h01, 8'h08, 8'h55, 8'h00, 8'h00);
        bump_err();
        end_frame();
        total_cnt++;
        if (frame_err !== 1'b1) $display("FAIL bad_addr_err: got %b, required 1", frame_err); else pass_cnt++;
        total_cnt++;
        if (err_count !== exp_err) $display("FAIL bad_addr_cnt: got %02h, required %02h", err_count, exp_err); else pass_cnt++;
        total_cnt++;
        if (regs !== exp_regs) $display("FAIL bad_regs: got %h, required %h", regs, exp_regs); else pass_cnt++;
        total_cnt++;
        if (strobe_cnt !== s0) $display("FAIL bad_strobes: got %0d, required 0", strobe_cnt - s0); else pass_cnt++;
        @(negedge clk);
        frame_active = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL err_clear: got %b, required 0", frame_err); else pass_cnt++;
        end_frame();
    endtask

    task automatic test_abort();
        int s0 = strobe_cnt;
        send_bytes(2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
        end_frame();
        push_wr(8'h02, 8'h5A);
        send_bytes(3, 8'h01, 8'h02, 8'h5A, 8'h00, 8'h00);
        end_frame();
        total_cnt++;
        if (regs !== exp_regs) $display("FAIL abort_regs: got %h, required %h", regs, exp_regs); else pass_cnt++;
        total_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL abort_count: got %0d, required 1", strobe_cnt - s0); else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL abort_frame_err: got %b, required 0", frame_err); else pass_cnt++;
    endtask

    task automatic test_edges();
        int s0 = strobe_cnt;
        // Bytes with frame_active low must be dropped.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_byte  = (i == 0) ? 8'h01 : (i == 1) ? 8'h04 : 8'hEE;
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (regs !== exp_regs) $display("FAIL inactive_regs: got %h, required %h", regs, exp_regs); else pass_cnt++;
        total_cnt++;
        if (strobe_cnt !== s0) $display("FAIL inactive_strobes: got %0d, required 0", strobe_cnt - s0); else pass_cnt++;
        push_wr(8'h01, 8'h44);
        send_bytes(4, 8'h01, 8'h01, 8'h44, 8'h55, 8'h00);
        bump_err();
        end_frame();
        total_cnt++;
        if (regs !== exp_regs) $display("FAIL extra_regs: got %h, required %h", regs, exp_regs); else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b1) $display("FAIL extra_err: got %b, required 1", frame_err); else pass_cnt++;
        total_cnt++;
        if (err_count !== exp_err) $display("FAIL extra_cnt: got %02h, required %02h", err_count, exp_err); else pass_cnt++;
        total_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL extra_count: got %0d, required 1", strobe_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        push_wr(8'h04, 8'hAA);
        send_bytes(3, 8'h02, 8'h04, 8'hAA, 8'h00, 8'h00);
        rx_byte  = 8'hBB;
        rx_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        exp_regs = '0;
        exp_err  = 8'h00;
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL midrst_pending: got %0d queued, required 0", exp_q.size()); else pass_cnt++;
        total_cnt++;
        if (regs !== '0) $display("FAIL midrst_regs: got %h, required 0", regs); else pass_cnt++;
        total_cnt++;
        if ({wr_strobe, frame_err} !== 2'b00) $display("FAIL midrst_flags: got %b, required 00", {wr_strobe, frame_err}); else pass_cnt++;
        total_cnt++;
        if ({wr_addr, wr_data, err_count} !== 24'h0)
            $display("FAIL midrst_wr: got %06h, required 000000", {wr_addr, wr_data, err_count});
        else pass_cnt++;
        @(negedge clk);
        rx_valid     = 1'b0;
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (regs !== '0) $display("FAIL postrst_regs: got %h, required 0", regs); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_bad_frames();
        test_abort();
        test_edges();
        test_reset_mid_burst();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d left, required 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
